// File: rtl/round_sequencer.sv
// round_sequencer: lights one of three targets per round, judges the player
// inputs against it inside a tick-timed window, and emits one-cycle score/miss
// pulses until the configured number of rounds has been played.
module round_sequencer #(
  parameter int         TICK_DIV   = 2000000,
  parameter int         LIT_TICKS  = 8,
  parameter int         GAP_TICKS  = 2,
  parameter int         NUM_ROUNDS = 20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  output logic [2:0] target,
  output logic       score_inc,
  output logic       miss_inc,
  output logic [7:0] round,
  output logic       busy,
  output logic       game_over
);

  localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [7:0]     SEED        = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [8:0]     GAP_LIMIT   = 9'(GAP_TICKS);
  localparam logic [8:0]     LIT_LIMIT   = 9'(LIT_TICKS);
  localparam logic [7:0]     ROUND_LIMIT = 8'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    in_r;
  logic [7:0]    lfsr;
  logic [7:0]    lfsr_mod3;
  logic [PW-1:0] presc;
  logic [7:0]    tick_cnt;
  logic          tick;
  logic [8:0]    tick_sum;
  logic [2:0]    target_next;
  logic          score_next;
  logic          miss_next;
  logic [7:0]    round_next;
  logic [7:0]    round_plus;
  logic          hit;
  logic          wrong;
  logic          timeout;

  // tick_sum is the tick count including a tick landing this cycle, so both
  // the gap and the lit window end in the cycle their last tick occurs.
  assign tick       = ((state == GAP) || (state == LIT)) && (presc == PRESC_MAX);
  assign tick_sum   = {1'b0, tick_cnt} + {8'd0, tick};
  assign lfsr_mod3  = lfsr % 8'd3;
  assign round_plus = round + 8'd1;
  assign hit        = |(in_r & target);
  assign wrong      = |(in_r & ~target);
  assign timeout    = (tick_sum >= LIT_LIMIT);
  assign busy       = (state == GAP) || (state == LIT);
  assign game_over  = (state == DONE);

  // Next-state, lamp, pulse and round decisions for the game flow.
  always_comb begin
    state_next  = state;
    target_next = target;
    score_next  = 1'b0;
    miss_next   = 1'b0;
    round_next  = round;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = GAP;
          round_next = 8'd0;
        end
      end
      GAP: begin
        target_next = 3'b000;
        if ((tick_sum >= GAP_LIMIT) && (in_r == 3'b000)) begin
          state_next  = LIT;
          target_next = 3'b001 << lfsr_mod3[1:0];
        end
      end
      LIT: begin
        if (hit || wrong || timeout) begin
          score_next  = hit;
          miss_next   = ~hit;
          target_next = 3'b000;
          round_next  = round_plus;
          state_next  = (round_plus == ROUND_LIMIT) ? DONE : GAP;
        end
      end
      DONE: begin
        if (start) begin
          state_next = GAP;
          round_next = 8'd0;
        end
      end
      default: begin
        state_next  = IDLE;
        target_next = 3'b000;
        round_next  = 8'd0;
      end
    endcase
  end

  // State, input capture, LFSR, timing counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_r      <= 3'b000;
      lfsr      <= SEED;
      presc     <= '0;
      tick_cnt  <= 8'd0;
      target    <= 3'b000;
      score_inc <= 1'b0;
      miss_inc  <= 1'b0;
      round     <= 8'd0;
    end else begin
      state     <= state_next;
      in_r      <= {in2, in1, in0};
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      target    <= target_next;
      score_inc <= score_next;
      miss_inc  <= miss_next;
      round     <= round_next;
      if ((state_next != state) || (state == IDLE) || (state == DONE)) begin
        presc    <= '0;
        tick_cnt <= 8'd0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && (tick_cnt != 8'hFF)) begin
          tick_cnt <= tick_cnt + 8'd1;
        end
      end
    end
  end

endmodule
